// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the integer register file / scoreboard and the control-word layout
// used by the writeback stage.
package regfile_scoreboard_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned AW        = $clog2(REG_COUNT);

  localparam logic [AW-1:0] REG_X0 = AW'(0);

  // Control word {rf_wb, wb_src[1:0], pc_src, rd[4:0]} bit positions
  localparam int unsigned CW_W          = 9;
  localparam int unsigned CW_RD_LSB     = 0;
  localparam int unsigned CW_RD_MSB     = 4;
  localparam int unsigned CW_PC_SRC_BIT = 5;
  localparam int unsigned CW_WB_SRC_LSB = 6;
  localparam int unsigned CW_WB_SRC_MSB = 7;
  localparam int unsigned CW_RF_WB_BIT  = 8;

  typedef struct packed {
    logic          rf_wb;
    logic [1:0]    wb_src;
    logic          pc_src;
    logic [AW-1:0] rd;
  } ctrl_word_t;

endpackage

// File: rtl/regfile_scoreboard_bank.sv
// Register storage: one write port, two combinational read ports with optional
// same-cycle write-through and x0 hard-wired to zero.
module regfile_scoreboard_bank
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN      = regfile_scoreboard_pkg::XLEN,
  parameter int unsigned REG_COUNT = regfile_scoreboard_pkg::REG_COUNT,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_i,
  input  logic [$clog2(REG_COUNT)-1:0] waddr_i,
  input  logic [XLEN-1:0]              wdata_i,
  input  logic [$clog2(REG_COUNT)-1:0] raddr1_i,
  input  logic [$clog2(REG_COUNT)-1:0] raddr2_i,
  output logic [XLEN-1:0]              rdata1_o,
  output logic [XLEN-1:0]              rdata2_o
);

  localparam int unsigned    AW = $clog2(REG_COUNT);
  localparam logic [AW-1:0] X0 = AW'(REG_X0);

  logic [XLEN-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != X0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == X0) begin
      rdata1_o = '0;
    end else if (BYPASS && we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == X0) begin
      rdata2_o = '0;
    end else if (BYPASS && we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural RV32I register file with a per-register pending-write scoreboard that
// raises RAW/WAW stalls to decode and flags unmatched writeback/kill events.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN      = regfile_scoreboard_pkg::XLEN,
  parameter int unsigned REG_COUNT = regfile_scoreboard_pkg::REG_COUNT,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_rf_wb,
  input  logic [$clog2(REG_COUNT)-1:0] wb_rd,
  input  logic [XLEN-1:0]              wb_data,
  input  logic [$clog2(REG_COUNT)-1:0] rs1_addr,
  input  logic [$clog2(REG_COUNT)-1:0] rs2_addr,
  output logic [XLEN-1:0]              rs1_data,
  output logic [XLEN-1:0]              rs2_data,
  input  logic                         issue_valid,
  input  logic                         issue_rf_wb,
  input  logic [$clog2(REG_COUNT)-1:0] issue_rd,
  input  logic                         kill_valid,
  input  logic [$clog2(REG_COUNT)-1:0] kill_rd,
  output logic                         stall,
  output logic                         sb_error
);

  localparam int unsigned    AW = $clog2(REG_COUNT);
  localparam logic [AW-1:0] X0 = AW'(REG_X0);

  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [REG_COUNT-1:0] wb_clr, k_clr, pend_eff, set_vec;
  logic                 sb_error_q, sb_error_d;
  logic                 stall_c;

  regfile_scoreboard_bank #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT),
    .BYPASS    (BYPASS)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_rf_wb),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  // Same-cycle writeback/kill release the hazard before the stall is evaluated
  always_comb begin
    wb_clr  = '0;
    k_clr   = '0;
    set_vec = '0;
    if (wb_rf_wb && (wb_rd != X0))     wb_clr[wb_rd] = 1'b1;
    if (kill_valid && (kill_rd != X0)) k_clr[kill_rd] = 1'b1;
    pend_eff = pending_q & ~wb_clr & ~k_clr;
    stall_c  = issue_valid && (pend_eff[rs1_addr] || pend_eff[rs2_addr] ||
                               (issue_rf_wb && pend_eff[issue_rd]));
    if (issue_valid && !stall_c && issue_rf_wb && (issue_rd != X0)) set_vec[issue_rd] = 1'b1;
    pending_d  = pend_eff | set_vec;
    sb_error_d = sb_error_q | (|((wb_clr | k_clr) & ~pending_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      sb_error_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      sb_error_q <= sb_error_d;
    end
  end

  assign stall    = stall_c;
  assign sb_error = sb_error_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: the driver pushes model-predicted outputs per cycle, a monitor pops and compares.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_rf_wb;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        issue_valid, issue_rf_wb;
  logic [4:0]  issue_rd;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        stall, sb_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stl;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_err;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .wb_rf_wb    (wb_rf_wb),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .issue_valid (issue_valid),
    .issue_rf_wb (issue_rf_wb),
    .issue_rd    (issue_rd),
    .kill_valid  (kill_valid),
    .kill_rd     (kill_rd),
    .stall       (stall),
    .sb_error    (sb_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_rf_wb && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  // A register still blocks only if no writeback or kill retires it this cycle
  function automatic bit m_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (wb_rf_wb && wb_rd == a) return 1'b0;
    if (kill_valid && kill_rd == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic cycle(input logic r, input logic wb, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic iv, input logic irf, input logic [4:0] ird,
                       input logic kv, input logic [4:0] krd, input string name);
    exp_t e;
    bit   st;
    @(posedge clk);
    #1;
    rst = r; wb_rf_wb = wb; wb_rd = wrd; wb_data = wd;
    rs1_addr = a1; rs2_addr = a2;
    issue_valid = iv; issue_rf_wb = irf; issue_rd = ird;
    kill_valid = kv; kill_rd = krd;
    st = iv && (m_busy(a1) || m_busy(a2) || (irf && m_busy(ird)));
    if (!r) begin
      e.rs1 = m_read(a1); e.rs2 = m_read(a2); e.stl = st; e.err = m_err; e.name = name;
      exp_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
      m_err = 1'b0;
    end else begin
      if (wb && wrd != 5'd0 && !m_pend[wrd]) m_err = 1'b1;
      if (kv && krd != 5'd0 && !m_pend[krd]) m_err = 1'b1;
      if (wb && wrd != 5'd0) begin m_regs[wrd] = wd; m_pend[wrd] = 1'b0; end
      if (kv && krd != 5'd0) m_pend[krd] = 1'b0;
      if (iv && !st && irf && ird != 5'd0) m_pend[ird] = 1'b1;
    end
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input string name);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, name);
  endtask

  task automatic check(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "rs1_data", rs1_data, e.rs1);
      check(e.name, "rs2_data", rs2_data, e.rs2);
      check(e.name, "stall", 32'(stall), 32'(e.stl));
      check(e.name, "sb_error", 32'(sb_error), 32'(e.err));
    end
  end

  initial begin
    logic        r, wb, iv, irf, kv;
    logic [4:0]  wrd, a1, a2, ird, krd;
    logic [31:0] wd;
    rst = 1'b1; wb_rf_wb = 1'b0; wb_rd = '0; wb_data = '0; rs1_addr = '0; rs2_addr = '0;
    issue_valid = 1'b0; issue_rf_wb = 1'b0; issue_rd = '0; kill_valid = 1'b0; kill_rd = '0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    m_err = 1'b0;

    // Reset and read every register back as zero
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "reset");
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "reset");
    for (int i = 1; i < 32; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i), 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, "post_reset_read");
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "wb_x5");
    idle(5'd5, 5'd0, "read_x5");

    // x0 is never written, never pending
    cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "wb_x0");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, "issue_x0");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, "no_stall_x0");

    // Write-through bypass
    cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "bypass_x7");
    idle(5'd0, 5'd7, "read_x7");

    // RAW stall released by same-cycle writeback
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, "issue_rd3");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, "raw_stall");
    cycle(1'b0, 1'b1, 5'd3, 32'h11, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, "raw_release");

    // WAW stall, then set wins over same-cycle clear
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, "issue_rd4");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, "waw_stall");
    cycle(1'b0, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, "wb_issue_rd4");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, "still_pending_x4");
    cycle(1'b0, 1'b1, 5'd4, 32'h45, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "wb_x4");

    // Kill drops pending; a later orphan writeback flags sb_error but still writes
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, "issue_rd9");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, "kill_x9");
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, "no_stall_x9");
    cycle(1'b0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "orphan_wb_x9");
    idle(5'd9, 5'd0, "sb_error_set");

    // Randomized traffic on a small register window to provoke hazards
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "reset");
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      wrd = 5'($urandom_range(0, 7));
      wb  = ($urandom_range(0, 1) == 1) && (m_pend[wrd] || $urandom_range(0, 15) == 0);
      wd  = $urandom;
      krd = 5'($urandom_range(0, 7));
      kv  = ($urandom_range(0, 5) == 0) && (m_pend[krd] || $urandom_range(0, 15) == 0);
      a1  = 5'($urandom_range(0, 7));
      a2  = 5'($urandom_range(0, 7));
      iv  = ($urandom_range(0, 9) < 7);
      irf = ($urandom_range(0, 3) != 0);
      ird = 5'($urandom_range(0, 7));
      cycle(r, wb, wrd, wd, a1, a2, iv, irf, ird, kv, krd, "random");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
